// File: rtl/square_pkg.sv
// Shared widths and result bit positions for the 3-bit squarer.
//   IN_W  : operand width ({A,B,C})
//   OUT_W : result width ({a,b,c,d,e,f})
//   S_*_BIT : position of each named output bit inside the result vector
package square_pkg;

  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 6;

  localparam int unsigned S_A_BIT = 5;
  localparam int unsigned S_B_BIT = 4;
  localparam int unsigned S_C_BIT = 3;
  localparam int unsigned S_D_BIT = 2;
  localparam int unsigned S_E_BIT = 1;
  localparam int unsigned S_F_BIT = 0;

endpackage

// File: rtl/square_core.sv
// Purely combinational 3-bit to 6-bit squarer built as sum-of-products.
// Ports:
//   opnd : operand N, unsigned 0..7 (MSB first)
//   sq   : N*N, unsigned 0..49
module square_core
  import square_pkg::*;
(
  input  logic [IN_W-1:0]  opnd,
  output logic [OUT_W-1:0] sq
);

  logic x, y, z;

  assign x = opnd[2];
  assign y = opnd[1];
  assign z = opnd[0];

  // Each result bit read off the 8-entry truth table.
  always_comb begin
    sq          = '0;
    sq[S_A_BIT] = x & y;                          // 6,7
    sq[S_B_BIT] = (x & ~y) | (x & z);             // 4,5,7
    sq[S_C_BIT] = (~x & y & z) | (x & ~y & z);    // 3,5
    sq[S_D_BIT] = y & ~z;                         // 2,6
    sq[S_E_BIT] = 1'b0;                           // squares are never 2 or 3 mod 4
    sq[S_F_BIT] = z;                              // odd operand gives odd square
  end

endmodule

// File: rtl/square.sv
// Pipelined 3-bit squarer with valid tracking and registered outputs.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid, A,B,C : operand N = {A,B,C} qualified by in_valid
//   a..f            : registered square bits 5..0
//   out_valid       : in_valid delayed by PIPE_STAGES cycles
// PIPE_STAGES (1 or 2) is the latency from input sample to output.
module square
  import square_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic out_valid
);

  logic [IN_W-1:0]  core_in;
  logic             core_load;
  logic [OUT_W-1:0] core_sq;
  logic [OUT_W-1:0] res;
  logic             res_vld;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic [IN_W-1:0] opnd_q;
      logic            opnd_vld;

      // Operand stage: captures only qualified inputs so idle cycles hold data.
      always_ff @(posedge clk) begin
        if (rst) begin
          opnd_q   <= '0;
          opnd_vld <= 1'b0;
        end else begin
          opnd_vld <= in_valid;
          if (in_valid) begin
            opnd_q <= {A, B, C};
          end
        end
      end

      assign core_in   = opnd_q;
      assign core_load = opnd_vld;
    end else begin : g_one
      assign core_in   = {A, B, C};
      assign core_load = in_valid;
    end
  endgenerate

  square_core u_core (
    .opnd (core_in),
    .sq   (core_sq)
  );

  // Result stage: reset clears, otherwise loads only on a valid operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= core_load;
      if (core_load) begin
        res <= core_sq;
      end
    end
  end

  assign a         = res[S_A_BIT];
  assign b         = res[S_B_BIT];
  assign c         = res[S_C_BIT];
  assign d         = res[S_D_BIT];
  assign e         = res[S_E_BIT];
  assign f         = res[S_F_BIT];
  assign out_valid = res_vld;

endmodule

// File: tb/tb_square.sv
// Self-checking bench for square: one instance per legal latency, shared inputs,
// checked every cycle against a latency-queue reference model.
module tb_square;

  logic clk = 1'b0;
  logic rst, in_valid, A, B, C;
  logic a1, b1, c1, d1, e1, f1, v1;
  logic a2, b2, c2, d2, e2, f2, v2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: held result and valid per latency, plus the one
  // in-flight {valid, operand} for the two-stage instance.
  logic [5:0] h1, h2;
  logic       o1, o2;
  logic [3:0] p2;

  always #5 clk = ~clk;

  square #(.PIPE_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .C(C),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .out_valid(v1)
  );

  square #(.PIPE_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .C(C),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .out_valid(v2)
  );

  function automatic logic [5:0] sq(input logic [2:0] n);
    int v;
    v = int'(n) * int'(n);
    return 6'(v);
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the model from the sampled inputs, check both DUTs.
  task automatic tick();
    logic [3:0] cur;
    logic [3:0] popped;
    @(posedge clk);
    cur = {in_valid, A, B, C};
    if (rst) begin
      h1 = '0; h2 = '0; o1 = 1'b0; o2 = 1'b0; p2 = '0;
    end else begin
      o1 = cur[3];
      if (cur[3]) h1 = sq(cur[2:0]);
      popped = p2;
      p2     = cur;
      o2     = popped[3];
      if (popped[3]) h2 = sq(popped[2:0]);
    end
    #1;
    chk("p1_result", {a1, b1, c1, d1, e1, f1}, h1);
    chk("p1_valid",  6'(v1), 6'(o1));
    chk("p2_result", {a2, b2, c2, d2, e2, f2}, h2);
    chk("p2_valid",  6'(v2), 6'(o2));
    chk("p1_e_zero", 6'(e1), 6'd0);
    chk("p2_e_zero", 6'(e2), 6'd0);
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] n);
    rst      = r;
    in_valid = v;
    {A, B, C} = n;
    tick();
  endtask

  initial begin
    logic [2:0] n;
    h1 = '0; h2 = '0; o1 = 1'b0; o2 = 1'b0; p2 = '0;
    rst = 1'b1; in_valid = 1'b1; {A, B, C} = 3'b111;

    // Reset with live-looking inputs: everything must stay cleared.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 3'b111);
      chk("rst_res", {a1, b1, c1, d1, e1, f1}, 6'd0);
      chk("rst_vld", 6'(v1), 6'd0);
      chk("rst_res2", {a2, b2, c2, d2, e2, f2}, 6'd0);
      chk("rst_vld2", 6'(v2), 6'd0);
    end

    // Directed single-stage sequence with literal expectations.
    drive(1'b0, 1'b1, 3'b000); chk("dir_000", {a1, b1, c1, d1, e1, f1}, 6'b000000); chk("dir_v0", 6'(v1), 6'd1);
    drive(1'b0, 1'b1, 3'b100); chk("dir_100", {a1, b1, c1, d1, e1, f1}, 6'b010000); chk("dir_v1", 6'(v1), 6'd1);
    drive(1'b0, 1'b1, 3'b110); chk("dir_110", {a1, b1, c1, d1, e1, f1}, 6'b100100); chk("dir_v2", 6'(v1), 6'd1);
    drive(1'b0, 1'b1, 3'b111); chk("dir_111", {a1, b1, c1, d1, e1, f1}, 6'b110001); chk("dir_v3", 6'(v1), 6'd1);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 8; i++) begin
      n = 3'(i);
      drive(1'b0, 1'b1, n);
      chk("sweep_res", {a1, b1, c1, d1, e1, f1}, 6'(i * i));
      chk("sweep_f", 6'(f1), 6'(n[0]));
    end
    drive(1'b0, 1'b0, 3'b000);
    chk("sweep_tail2", {a2, b2, c2, d2, e2, f2}, 6'd49);

    // Gap: one valid then three idle cycles; result holds, valid pulses once.
    drive(1'b0, 1'b1, 3'b101);
    chk("gap_res", {a1, b1, c1, d1, e1, f1}, 6'b011001);
    chk("gap_vld", 6'(v1), 6'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'($urandom_range(7)));
      chk("gap_hold", {a1, b1, c1, d1, e1, f1}, 6'b011001);
      chk("gap_idle", 6'(v1), 6'd0);
    end

    // Reset right behind an in-flight operand on the two-stage instance.
    drive(1'b0, 1'b1, 3'b011);
    drive(1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      chk("flush_res2", {a2, b2, c2, d2, e2, f2}, 6'd0);
      chk("flush_vld2", 6'(v2), 6'd0);
      drive(1'b0, 1'b0, 3'b011);
    end

    // Randomized traffic with sparse resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(19) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 Parameter: PIPE_STAGES, default 1, number of register stages from input sample to output; legal values 1 or 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  qualifies A/B/C this cycle.
REQ-005 A  input  1  operand bit 2 (MSB).
REQ-006 B  input  1  operand bit 1.
REQ-007 C  input  1  operand bit 0 (LSB).
REQ-008 a  output  1  square bit 5 (MSB).
REQ-009 b  output  1  square bit 4.
REQ-010 c  output  1  square bit 3.
REQ-011 d  output  1  square bit 2.
REQ-012 e  output  1  square bit 1.
REQ-013 f  output  1  square bit 0 (LSB).
REQ-014 out_valid  output  1  a..f hold a new result this cycle.

Function
REQ-015 Operand N = {A,B,C}, unsigned 0..7; result S = N*N, unsigned 6-bit, range 0..49; no overflow possible.
REQ-016 {a,b,c,d,e,f} SHALL equal S computed from the operand sampled PIPE_STAGES rising edges earlier with in_valid=1.
REQ-017 out_valid SHALL be in_valid delayed by exactly PIPE_STAGES cycles.
REQ-018 When in_valid=0, the pipeline stage SHALL not load new data; outputs a..f hold their last result; out_valid deasserts after PIPE_STAGES cycles.
REQ-019 Back-to-back valid inputs SHALL be accepted every cycle (throughput 1 result/cycle), no stall or backpressure.
REQ-020 e SHALL be constant 0 in every cycle (square of an integer is never ≡2 or 3 mod 4).
REQ-021 f SHALL equal the sampled C (odd operand gives odd square).
REQ-022 Full truth table: 0->0, 1->1, 2->4, 3->9, 4->16, 5->25, 6->36, 7->49.
REQ-023 Outputs SHALL be driven only from registers; no combinational path from A/B/C to a..f.

Reset
REQ-024 While rst=1 at a rising edge: a..f SHALL become 0, out_valid SHALL become 0, and all pipeline stages SHALL be cleared.
REQ-025 rst SHALL dominate in_valid in the same cycle; inputs presented during reset are discarded.
REQ-026 Reset asserted mid-operation SHALL flush in-flight results; the first out_valid after release follows the first post-reset valid input by PIPE_STAGES cycles.

Structure
REQ-027 Package square_pkg SHALL hold IN_W=3, OUT_W=6 and the result bit-index constants.
REQ-028 One sub-module square_core SHALL implement the purely combinational 3-bit-to-6-bit squarer as sum-of-products logic; square wraps it with the valid pipeline and registers.

Verification
REQ-029 Reset: rst=1 for 2 cycles with A=B=C=1, in_valid=1 -> a..f=000000, out_valid=0 throughout.
REQ-030 Directed sequence (PIPE_STAGES=1), one per cycle: {A,B,C}=000,100,110,111 -> after 1 cycle a..f=000000, 010000, 100100, 110001 with out_valid=1.
REQ-031 Exhaustive sweep 0..7 back-to-back -> outputs 0,1,4,9,16,25,36,49 on consecutive cycles; e=0 and f=C every result.
REQ-032 Gap: valid 101, then in_valid=0 for 3 cycles -> a..f holds 011001, out_valid=1 for one cycle only.
REQ-033 Reset mid-stream (PIPE_STAGES=2): valid 011 followed by rst=1 next cycle -> 001001 never appears, out_valid stays 0.
